// File: rtl/disp_colour_pkg.sv
// ----------------------------------------------------------------------------
// disp_colour_pkg
//   Shared constants and helpers for the display colour-depth adapter.
//   - BAYER_xx      : 2x2 ordered-dither thresholds, indexed (y parity, x parity)
//   - bayer_threshold: looks up the threshold for a (y, x) parity pair
//   - widen_replicate: MSB-first bit replication of a narrow channel value
//   - sat_increment  : +1 that sticks at all-ones for a given channel width
// ----------------------------------------------------------------------------
package disp_colour_pkg;

  localparam int MAX_BPC = 16;

  localparam logic [1:0] BAYER_00 = 2'd0;
  localparam logic [1:0] BAYER_01 = 2'd2;
  localparam logic [1:0] BAYER_10 = 2'd3;
  localparam logic [1:0] BAYER_11 = 2'd1;

  localparam logic [MAX_BPC-1:0] ONE = 16'd1;

  function automatic logic [1:0] bayer_threshold(input logic yi, input logic xi);
    logic [1:0] t;
    case ({yi, xi})
      2'b00:   t = BAYER_00;
      2'b01:   t = BAYER_01;
      2'b10:   t = BAYER_10;
      default: t = BAYER_11;
    endcase
    return t;
  endfunction

  // Result is left-aligned in MAX_BPC bits; callers keep the top BPC_OUT bits.
  // Bit i from the top takes source bit (w_in-1 - i mod w_in), i.e. the input
  // repeated end to end starting from its MSB.
  function automatic logic [MAX_BPC-1:0] widen_replicate(input logic [MAX_BPC-1:0] c,
                                                         input int w_in);
    logic [MAX_BPC-1:0] r;
    logic [3:0] src;
    r = '0;
    for (int i = 0; i < MAX_BPC; i++) begin
      src = 4'(w_in - 1 - (i % w_in));
      r[4'(MAX_BPC - 1 - i)] = c[src];
    end
    return r;
  endfunction

  // Increment that never wraps: a value already at (2^w - 1) is returned as is.
  function automatic logic [MAX_BPC-1:0] sat_increment(input logic [MAX_BPC-1:0] q,
                                                       input int w);
    logic [MAX_BPC-1:0] top;
    top = MAX_BPC'((32'd1 << w) - 32'd1);
    return (q >= top) ? q : q + ONE;
  endfunction

endpackage

// File: rtl/disp_colour_chan.sv
// ----------------------------------------------------------------------------
// disp_colour_chan
//   One colour channel of the adapter: widen / pass / truncate / dither the
//   stage-1 value and register it as the board output (stage 2).
//   Ports:
//     clk, rst_n  : pixel clock, asynchronous active-low reset
//     colour      : stage-1 channel value (BPC_IN bits)
//     thresh      : stage-1 dither threshold shared by all channels
//     de          : stage-1 data enable; blanks the output when low
//     board       : registered board channel value (BPC_OUT bits)
// ----------------------------------------------------------------------------
module disp_colour_chan
  import disp_colour_pkg::*;
#(
  parameter int BPC_IN  = 5,
  parameter int BPC_OUT = 8,
  parameter int DITHER  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BPC_IN-1:0]  colour,
  input  logic [1:0]         thresh,
  input  logic               de,
  output logic [BPC_OUT-1:0] board
);

  logic [BPC_OUT-1:0] value;
  logic               dither_on;
  logic               unused_ok;

  assign dither_on = (DITHER != 0);

  // Not every width combination consumes all inputs (e.g. widening ignores
  // the threshold); fold them here so the remaining bits stay accounted for.
  assign unused_ok = ^{colour, thresh, dither_on};

  generate
    if (BPC_OUT == BPC_IN) begin : g_equal
      assign value = colour;
    end else if (BPC_OUT > BPC_IN) begin : g_widen
      logic [MAX_BPC-1:0] wide;
      logic               unused_wide;
      assign wide        = widen_replicate(MAX_BPC'(colour), BPC_IN);
      assign value       = wide[MAX_BPC-1 -: BPC_OUT];
      assign unused_wide = ^wide;
    end else begin : g_narrow
      localparam int D = BPC_IN - BPC_OUT;
      logic [BPC_OUT-1:0] q;
      logic [1:0]         f2;
      logic [MAX_BPC-1:0] inc;
      logic               unused_inc;

      assign q = colour[BPC_IN-1:D];

      // Only the top two dropped bits take part in the threshold compare;
      // with a single dropped bit it is scaled up into the 2-bit range.
      if (D == 1) begin : g_f1
        assign f2 = {colour[0], 1'b0};
      end else begin : g_fn
        assign f2 = colour[D-1 -: 2];
      end

      assign inc        = sat_increment(MAX_BPC'(q), BPC_OUT);
      assign unused_inc = ^inc;
      assign value      = (dither_on && (f2 > thresh)) ? inc[BPC_OUT-1:0] : q;
    end
  endgenerate

  // Stage-2 register; blanked pixels are forced to black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board <= '0;
    end else begin
      board <= de ? value : '0;
    end
  end

endmodule

// File: rtl/disp_colour_adapt.sv
// ----------------------------------------------------------------------------
// disp_colour_adapt
//   Two-stage registered colour-depth adapter between the core's display
//   outputs and the board video driver. Stage 1 captures inputs and works out
//   the ordered-dither threshold from x/y/frame parity; stage 2 (per channel)
//   produces the board colour. Sync and de follow the same two registers.
//   Ports:
//     clk_pix, rst_pix_n              : pixel clock, async active-low reset
//     disp_r/g/b                      : system colour, BPC_IN bits each
//     disp_hsync/vsync/de             : display timing
//     disp_frame                      : one-cycle start-of-frame pulse
//     board_r/g/b                     : board colour, BPC_OUT bits each
//     board_hsync/vsync/de            : timing aligned to board colour
// ----------------------------------------------------------------------------
module disp_colour_adapt
  import disp_colour_pkg::*;
#(
  parameter int BPC_IN   = 5,
  parameter int BPC_OUT  = 8,
  parameter int DITHER   = 1,
  parameter int TEMPORAL = 1
) (
  input  logic               clk_pix,
  input  logic               rst_pix_n,
  input  logic [BPC_IN-1:0]  disp_r,
  input  logic [BPC_IN-1:0]  disp_g,
  input  logic [BPC_IN-1:0]  disp_b,
  input  logic               disp_hsync,
  input  logic               disp_vsync,
  input  logic               disp_de,
  input  logic               disp_frame,
  output logic [BPC_OUT-1:0] board_r,
  output logic [BPC_OUT-1:0] board_g,
  output logic [BPC_OUT-1:0] board_b,
  output logic               board_hsync,
  output logic               board_vsync,
  output logic               board_de
);

  logic [BPC_IN-1:0] s1_r, s1_g, s1_b;
  logic              s1_hsync, s1_vsync, s1_de;
  logic [1:0]        s1_t;

  logic xp, yp, fp, de_prev;
  logic temporal_on;
  logic line_start, line_end, pix_x, xi, yi;
  logic [1:0] t_next;

  assign temporal_on = (TEMPORAL != 0);

  // The first active pixel of a line is always x parity 0, whatever xp was
  // left at by the previous line. Temporal mode flips both indices per frame.
  always_comb begin
    line_start = disp_de & ~de_prev;
    line_end   = de_prev & ~disp_de;
    pix_x      = line_start ? 1'b0 : xp;
    xi         = pix_x ^ (fp & temporal_on);
    yi         = yp ^ (fp & temporal_on);
    t_next     = bayer_threshold(yi, xi);
  end

  // Parity tracking. A frame pulse clears y even when it lands on the cycle
  // a line ends, so it takes priority over the end-of-line toggle.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      xp      <= 1'b0;
      yp      <= 1'b0;
      fp      <= 1'b0;
      de_prev <= 1'b0;
    end else begin
      de_prev <= disp_de;
      if (disp_de) begin
        xp <= ~pix_x;
      end
      if (disp_frame) begin
        yp <= 1'b0;
        fp <= ~fp;
      end else if (line_end) begin
        yp <= ~yp;
      end
    end
  end

  // Stage 1: capture inputs along with the threshold for this pixel.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_hsync <= 1'b0;
      s1_vsync <= 1'b0;
      s1_de    <= 1'b0;
      s1_t     <= '0;
    end else begin
      s1_r     <= disp_r;
      s1_g     <= disp_g;
      s1_b     <= disp_b;
      s1_hsync <= disp_hsync;
      s1_vsync <= disp_vsync;
      s1_de    <= disp_de;
      s1_t     <= t_next;
    end
  end

  // Stage 2 timing; colour stage 2 lives in the channel instances.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      board_hsync <= 1'b0;
      board_vsync <= 1'b0;
      board_de    <= 1'b0;
    end else begin
      board_hsync <= s1_hsync;
      board_vsync <= s1_vsync;
      board_de    <= s1_de;
    end
  end

  disp_colour_chan #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .DITHER(DITHER)) u_chan_r (
    .clk(clk_pix), .rst_n(rst_pix_n), .colour(s1_r), .thresh(s1_t), .de(s1_de), .board(board_r)
  );

  disp_colour_chan #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .DITHER(DITHER)) u_chan_g (
    .clk(clk_pix), .rst_n(rst_pix_n), .colour(s1_g), .thresh(s1_t), .de(s1_de), .board(board_g)
  );

  disp_colour_chan #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .DITHER(DITHER)) u_chan_b (
    .clk(clk_pix), .rst_n(rst_pix_n), .colour(s1_b), .thresh(s1_t), .de(s1_de), .board(board_b)
  );

endmodule

// File: tb/tb_disp_colour_adapt.sv
// ----------------------------------------------------------------------------
// tb_disp_colour_adapt
//   Drives six adapter configurations from one shared random video stream and
//   compares every output against a behavioural model that tracks pixel
//   position as plain x/line/frame counts.
//   Configs: 5->8 widen, 8->5 truncate, 8->6 static dither, 8->6 temporal
//   dither, 8->7 temporal dither (one dropped bit), 8->8 pass-through.
// ----------------------------------------------------------------------------
module tb_disp_colour_adapt;

  localparam int NDUT = 6;
  localparam int CFG_IN   [NDUT] = '{5, 8, 8, 8, 8, 8};
  localparam int CFG_OUT  [NDUT] = '{8, 5, 6, 6, 7, 8};
  localparam int CFG_DITH [NDUT] = '{1, 0, 1, 1, 1, 1};
  localparam int CFG_TEMP [NDUT] = '{1, 1, 0, 1, 1, 1};

  typedef struct packed {
    logic [NDUT-1:0][2:0][7:0] col;
    logic                      hs;
    logic                      vs;
    logic                      de;
  } exp_t;

  logic clk_pix = 1'b0;
  logic rst_pix_n = 1'b0;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic in_hs = 1'b0, in_vs = 1'b0, in_de = 1'b0, in_frame = 1'b0;

  logic [7:0] o0_r, o0_g, o0_b;
  logic [4:0] o1_r, o1_g, o1_b;
  logic [5:0] o2_r, o2_g, o2_b;
  logic [5:0] o3_r, o3_g, o3_b;
  logic [6:0] o4_r, o4_g, o4_b;
  logic [7:0] o5_r, o5_g, o5_b;
  logic [NDUT-1:0] o_hs, o_vs, o_de;

  logic [NDUT-1:0][2:0][7:0] act_col;

  int n_compared = 0;
  int n_mismatch = 0;

  exp_t exp_q[$];
  int prev_de_m, xcount, line_cnt, frame_cnt;
  int bayer_tab [2][2] = '{'{0, 2}, '{3, 1}};
  logic [7:0] pick_tab [8] = '{8'h00, 8'hFF, 8'h87, 8'h81, 8'h10, 8'h1F, 8'h7F, 8'h80};

  always #5 clk_pix = ~clk_pix;

  disp_colour_adapt #(.BPC_IN(5), .BPC_OUT(8), .DITHER(1), .TEMPORAL(1)) u_w58 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
    .disp_r(in_r[4:0]), .disp_g(in_g[4:0]), .disp_b(in_b[4:0]),
    .disp_hsync(in_hs), .disp_vsync(in_vs), .disp_de(in_de), .disp_frame(in_frame),
    .board_r(o0_r), .board_g(o0_g), .board_b(o0_b),
    .board_hsync(o_hs[0]), .board_vsync(o_vs[0]), .board_de(o_de[0]));

  disp_colour_adapt #(.BPC_IN(8), .BPC_OUT(5), .DITHER(0), .TEMPORAL(1)) u_t85 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
    .disp_r(in_r), .disp_g(in_g), .disp_b(in_b),
    .disp_hsync(in_hs), .disp_vsync(in_vs), .disp_de(in_de), .disp_frame(in_frame),
    .board_r(o1_r), .board_g(o1_g), .board_b(o1_b),
    .board_hsync(o_hs[1]), .board_vsync(o_vs[1]), .board_de(o_de[1]));

  disp_colour_adapt #(.BPC_IN(8), .BPC_OUT(6), .DITHER(1), .TEMPORAL(0)) u_d86s (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
    .disp_r(in_r), .disp_g(in_g), .disp_b(in_b),
    .disp_hsync(in_hs), .disp_vsync(in_vs), .disp_de(in_de), .disp_frame(in_frame),
    .board_r(o2_r), .board_g(o2_g), .board_b(o2_b),
    .board_hsync(o_hs[2]), .board_vsync(o_vs[2]), .board_de(o_de[2]));

  disp_colour_adapt #(.BPC_IN(8), .BPC_OUT(6), .DITHER(1), .TEMPORAL(1)) u_d86t (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
    .disp_r(in_r), .disp_g(in_g), .disp_b(in_b),
    .disp_hsync(in_hs), .disp_vsync(in_vs), .disp_de(in_de), .disp_frame(in_frame),
    .board_r(o3_r), .board_g(o3_g), .board_b(o3_b),
    .board_hsync(o_hs[3]), .board_vsync(o_vs[3]), .board_de(o_de[3]));

  disp_colour_adapt #(.BPC_IN(8), .BPC_OUT(7), .DITHER(1), .TEMPORAL(1)) u_d87t (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
    .disp_r(in_r), .disp_g(in_g), .disp_b(in_b),
    .disp_hsync(in_hs), .disp_vsync(in_vs), .disp_de(in_de), .disp_frame(in_frame),
    .board_r(o4_r), .board_g(o4_g), .board_b(o4_b),
    .board_hsync(o_hs[4]), .board_vsync(o_vs[4]), .board_de(o_de[4]));

  disp_colour_adapt #(.BPC_IN(8), .BPC_OUT(8), .DITHER(1), .TEMPORAL(1)) u_e88 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
    .disp_r(in_r), .disp_g(in_g), .disp_b(in_b),
    .disp_hsync(in_hs), .disp_vsync(in_vs), .disp_de(in_de), .disp_frame(in_frame),
    .board_r(o5_r), .board_g(o5_g), .board_b(o5_b),
    .board_hsync(o_hs[5]), .board_vsync(o_vs[5]), .board_de(o_de[5]));

  // Gather every instance's colour into one zero-extended table for checking.
  always_comb begin
    act_col[0] = {o0_b, o0_g, o0_r};
    act_col[1] = {{3'b0, o1_b}, {3'b0, o1_g}, {3'b0, o1_r}};
    act_col[2] = {{2'b0, o2_b}, {2'b0, o2_g}, {2'b0, o2_r}};
    act_col[3] = {{2'b0, o3_b}, {2'b0, o3_g}, {2'b0, o3_r}};
    act_col[4] = {{1'b0, o4_b}, {1'b0, o4_g}, {1'b0, o4_r}};
    act_col[5] = {o5_b, o5_g, o5_r};
  end

  // Reference colour conversion straight from the width rules.
  function automatic int model_colour(int c, int bin, int bout, int dith, int tval, bit pix_de);
    longint acc;
    int bits, dd, q, f, f2;
    if (!pix_de) return 0;
    if (bout == bin) return c;
    if (bout > bin) begin
      acc  = 0;
      bits = 0;
      while (bits < bout) begin
        acc  = (acc << bin) | longint'(c);
        bits += bin;
      end
      return int'(acc >> (bits - bout));
    end
    dd = bin - bout;
    q  = c >> dd;
    if (dith == 0) return q;
    f  = c & ((1 << dd) - 1);
    f2 = (dd >= 2) ? (f >> (dd - 2)) : (f << 1);
    if (f2 > tval && q != (1 << bout) - 1) q++;
    return q;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic compareAll(input exp_t e, input string where);
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("%s dut%0d ch%0d", where, d, k),
                    int'(act_col[d][k]), int'(e.col[d][k]));
      end
      checkOutput($sformatf("%s dut%0d hs/vs/de", where, d),
                  int'({o_hs[d], o_vs[d], o_de[d]}), int'({e.hs, e.vs, e.de}));
    end
  endtask

  task automatic resetModel();
    exp_t z;
    z = '0;
    prev_de_m = 0;
    xcount    = 0;
    line_cnt  = 0;
    frame_cnt = 0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  function automatic logic [7:0] pickColour(bit sat);
    if (sat) return 8'hFF;
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
    return pick_tab[$urandom_range(0, 7)];
  endfunction

  // One pixel clock: check the result due from two cycles back, drive the
  // new inputs, then advance the position model.
  task automatic applyStimulus(input bit de_i, input bit hs_i, input bit vs_i,
                               input bit fr_i, input bit sat);
    exp_t e;
    int xpar, ypar, fpar, xi, yi, tval, c;
    logic [7:0] cols [3];
    @(negedge clk_pix);
    if (exp_q.size() == 2) compareAll(exp_q.pop_front(), "pipe");
    cols[0] = pickColour(sat);
    cols[1] = pickColour(sat);
    cols[2] = pickColour(sat);
    in_r = cols[0]; in_g = cols[1]; in_b = cols[2];
    in_de = de_i; in_hs = hs_i; in_vs = vs_i; in_frame = fr_i;

    if (de_i && prev_de_m == 0) xcount = 0;
    xpar = xcount % 2;
    ypar = line_cnt % 2;
    fpar = frame_cnt % 2;
    e = '0;
    for (int d = 0; d < NDUT; d++) begin
      xi   = CFG_TEMP[d] != 0 ? (xpar ^ fpar) : xpar;
      yi   = CFG_TEMP[d] != 0 ? (ypar ^ fpar) : ypar;
      tval = bayer_tab[yi][xi];
      for (int k = 0; k < 3; k++) begin
        c = (CFG_IN[d] == 5) ? int'(cols[k] & 8'h1F) : int'(cols[k]);
        e.col[d][k] = 8'(model_colour(c, CFG_IN[d], CFG_OUT[d], CFG_DITH[d], tval, de_i));
      end
    end
    e.hs = hs_i;
    e.vs = vs_i;
    e.de = de_i;
    exp_q.push_back(e);

    if (de_i) xcount++;
    if (fr_i) begin
      line_cnt = 0;
      frame_cnt++;
    end else if (prev_de_m == 1 && !de_i) begin
      line_cnt++;
    end
    prev_de_m = de_i ? 1 : 0;
  endtask

  // A frame of 3..5 lines of random length. Sometimes the frame pulse lands
  // on the cycle the last line's de falls, otherwise it sits in vblank.
  task automatic runFrame(input bit sat);
    int nlines, w;
    bit early;
    nlines = $urandom_range(3, 5);
    early  = ($urandom_range(0, 2) == 0);
    for (int l = 0; l < nlines; l++) begin
      w = $urandom_range(2, 9);
      for (int p = 0; p < w; p++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, sat);
      for (int b = 0; b < 4; b++)
        applyStimulus(1'b0, (b == 1 || b == 2), 1'b0, (early && l == nlines - 1 && b == 0), sat);
    end
    for (int b = 0; b < 3; b++) applyStimulus(1'b0, 1'b0, 1'b1, (!early && b == 1), sat);
  endtask

  task automatic idleInputs();
    in_r = '0; in_g = '0; in_b = '0;
    in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0; in_frame = 1'b0;
  endtask

  task automatic releaseReset();
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    resetModel();
  endtask

  // Pull reset in the middle of an active line, between clock edges, and
  // expect every output to drop without waiting for a clock.
  task automatic resetMidLine();
    exp_t z;
    z = '0;
    for (int p = 0; p < 4; p++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_pix_n = 1'b0;
    idleInputs();
    #1;
    compareAll(z, "async_reset");
    @(negedge clk_pix);
    @(negedge clk_pix);
    releaseReset();
  endtask

  initial begin
    exp_t z;
    z = '0;
    $display("[TB] start");
    idleInputs();
    repeat (3) @(negedge clk_pix);
    compareAll(z, "reset_state");
    releaseReset();

    for (int f = 0; f < 6; f++) runFrame(1'b0);
    runFrame(1'b1);
    for (int f = 0; f < 2; f++) runFrame(1'b0);
    resetMidLine();
    for (int f = 0; f < 4; f++) runFrame(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
